// File: rtl/kuantalama_tablo.sv
// Purpose : JPEG quantisation table store; loads Annex K defaults after reset,
//           then serves raster/zigzag reads as IEEE-754 single-precision floats.
// Latency : 2 cycles from request acceptance to data_valid_o, 1 result/cycle.
// Backpres: valid/ready on both sides; a stalled output freezes the whole pipe
//           and drops req_ready_o until data_ready_i returns.
//
// Ports
//   clk_i, rst_ni              single clock, synchronous active-low reset
//   wr_en_i/wr_tbl_i/wr_addr_i/wr_data_i
//                              runtime table write (raster address, 8-bit Q)
//   req_valid_i/req_ready_o/req_tbl_i/req_addr_i/zigzag_i
//                              read request; zigzag_i selects zigzag indexing
//   data_valid_o/data_ready_i/data_o
//                              read result as a float
//   init_done_o                default tables loaded, block in RUN
module kuantalama_tablo #(
  parameter int N_TABLE = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_tbl_i,
  input  logic [5:0]        wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_tbl_i,
  input  logic [5:0]        req_addr_i,
  input  logic              zigzag_i,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              init_done_o
);

  localparam int         DEPTH = N_TABLE * 64;
  localparam int         AW    = $clog2(DEPTH);
  localparam logic [7:0] LAST  = 8'(DEPTH - 1);
  localparam logic [2:0] NT    = 3'(N_TABLE);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Annex K luminance, raster order.
  localparam logic [7:0] LUMA_Q [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  // Annex K chrominance, raster order.
  localparam logic [7:0] CHROMA_Q [64] = '{
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  // Zigzag position -> raster address.
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Q is an integer 1..255, so the float is exact: exponent from the leading
  // one, remaining bits left-aligned into the mantissa. Q=0 maps to +0.0.
  function automatic logic [31:0] q_to_float(input logic [7:0] q);
    logic [2:0] msb;
    logic [7:0] norm;
    msb = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) msb = 3'(i);
    end
    norm = q << (3'd7 - msb);
    if (q == 8'd0) q_to_float = 32'd0;
    else           q_to_float = {1'b0, 8'd127 + {5'd0, msb}, norm[6:0], 16'd0};
  endfunction

  logic [0:0]    state;
  logic [7:0]    init_cnt;
  logic [7:0]    q_mem [DEPTH];
  logic          in_run;

  logic [7:0]    init_val;
  logic [AW-1:0] init_idx;
  logic          wr_ok;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_val;
  logic [5:0]    rd_raster;
  logic          rd_ok;
  logic [AW-1:0] rd_idx;

  logic          s1_vld;
  logic [7:0]    s1_q;

  assign in_run      = (state == ST_RUN);
  assign req_ready_o = in_run && (!data_valid_o || data_ready_i);

  assign init_val = (init_cnt[7:6] == 2'd0) ? LUMA_Q[init_cnt[5:0]]
                                            : CHROMA_Q[init_cnt[5:0]];
  assign init_idx = AW'(init_cnt);

  assign wr_ok  = in_run && wr_en_i && ({1'b0, wr_tbl_i} < NT);
  assign wr_idx = AW'({wr_tbl_i, wr_addr_i});
  // A zero divisor is meaningless for quantisation; clamp it to 1.
  assign wr_val = (wr_data_i == 8'd0) ? 8'd1 : wr_data_i;

  assign rd_raster = zigzag_i ? ZIGZAG[req_addr_i] : req_addr_i;
  assign rd_ok     = ({1'b0, req_tbl_i} < NT);
  assign rd_idx    = AW'({req_tbl_i, rd_raster});

  // Table storage. INIT owns the write port; runtime writes only in RUN.
  // The registered read in the pipeline sees the pre-write contents, which
  // gives read-old-value on a same-entry collision.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state == ST_INIT) q_mem[init_idx] <= init_val;
      else if (wr_ok)       q_mem[wr_idx]   <= wr_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_INIT;
      init_cnt     <= 8'd0;
      init_done_o  <= 1'b0;
      s1_vld       <= 1'b0;
      s1_q         <= 8'd0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
    end else begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 8'd1;
        if (init_cnt == LAST) begin
          state       <= ST_RUN;
          init_done_o <= 1'b1;
        end
      end

      // Both stages move together; req_ready_o already folds in the
      // downstream stall, so a held output freezes stage 1 as well.
      if (req_ready_o) begin
        s1_vld       <= req_valid_i;
        s1_q         <= (req_valid_i && rd_ok) ? q_mem[rd_idx] : 8'd0;
        data_valid_o <= s1_vld;
        data_o       <= DATA_W'(q_to_float(s1_q));
      end
    end
  end

endmodule

// File: tb/tb_kuantalama_tablo.sv
module tb_kuantalama_tablo;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wr_en_i;
  logic [1:0]  wr_tbl_i;
  logic [5:0]  wr_addr_i;
  logic [7:0]  wr_data_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_tbl_i;
  logic [5:0]  req_addr_i;
  logic        zigzag_i;
  logic        data_valid_o;
  logic        data_ready_i;
  logic [31:0] data_o;
  logic        init_done_o;

  always #5 clk_i = ~clk_i;

  kuantalama_tablo #(.N_TABLE(2), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_en_i(wr_en_i), .wr_tbl_i(wr_tbl_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_tbl_i(req_tbl_i),
    .req_addr_i(req_addr_i), .zigzag_i(zigzag_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
    .init_done_o(init_done_o)
  );

  int errors = 0;
  int checks = 0;

  int luma [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99
  };
  int chroma_tl [16] = '{17, 18, 24, 47, 18, 21, 26, 66, 24, 26, 56, 99, 47, 66, 99, 99};

  int mdl [4][64];
  int zz  [64];

  typedef struct {
    logic [31:0] val;
    int          cnt;  // advancing edges since acceptance; visible at 2
  } item_t;
  item_t q [$];

  int   since    = 0;   // clock edges since reset release
  logic model_ok = 1'b0;
  logic acc      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact integer -> single via the double encoding (rebias 1023 -> 127).
  function automatic logic [31:0] fl(input int v);
    logic [63:0] b;
    if (v == 0) return 32'd0;
    b = $realtobits(real'(v));
    return {1'b0, 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic void build_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
      else            for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
    end
  endfunction

  function automatic void load_defaults();
    for (int a = 0; a < 64; a++) begin
      int r = a / 8;
      int c = a % 8;
      mdl[0][a] = luma[a];
      mdl[1][a] = (r < 4 && c < 4) ? chroma_tl[r * 4 + c] : 99;
    end
  endfunction

  function automatic logic [31:0] ref_read(input logic [1:0] t, input logic [5:0] a, input logic z);
    if (t >= 2) return 32'd0;
    return fl(mdl[t][z ? zz[a] : int'(a)]);
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic        edv, erdy, do_acc, do_pop, do_wr;
    logic [31:0] v;
    item_t       it;
    #4;
    edv  = (q.size() > 0) && (q[0].cnt >= 2);
    erdy = (since >= 128) && (!edv || data_ready_i);
    if (model_ok) begin
      chk("req_ready", {31'd0, req_ready_o}, {31'd0, erdy});
      chk("data_valid", {31'd0, data_valid_o}, {31'd0, edv});
      chk("init_done", {31'd0, init_done_o}, 32'(since >= 128));
      if (edv) chk("data", data_o, q[0].val);
    end
    do_acc = rst_ni && erdy && req_valid_i;
    acc    = do_acc;
    v      = ref_read(req_tbl_i, req_addr_i, zigzag_i);
    do_pop = edv && data_ready_i;
    do_wr  = rst_ni && wr_en_i && (since >= 128) && (wr_tbl_i < 2);
    @(posedge clk_i);
    if (!rst_ni) begin
      q.delete();
      since    = 0;
      load_defaults();
      model_ok = 1'b1;
    end else begin
      if (erdy) begin
        if (do_pop) q.delete(0);
        foreach (q[i]) q[i].cnt++;
        if (do_acc) begin it.val = v; it.cnt = 1; q.push_back(it); end
      end
      if (do_wr) mdl[wr_tbl_i][wr_addr_i] = (wr_data_i == 8'd0) ? 1 : int'(wr_data_i);
      since++;
    end
    #1;
  endtask

  task automatic req(input logic [1:0] t, input logic [5:0] a, input logic z);
    req_tbl_i = t; req_addr_i = a; zigzag_i = z; req_valid_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) chk("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [1:0] t, input logic [5:0] a, input logic [7:0] d);
    wr_en_i = 1'b1; wr_tbl_i = t; wr_addr_i = a; wr_data_i = d;
    cycle();
    wr_en_i = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] t, input logic [5:0] a,
                          input logic z, input logic [31:0] exp);
    req(t, a, z);
    req_valid_i = 1'b0;
    cycle();
    chk({tag, "_vld"}, {31'd0, data_valid_o}, 32'd1);
    chk(tag, data_o, exp);
    cycle();
  endtask

  initial begin
    build_zigzag();
    load_defaults();
    rst_ni = 1'b0; wr_en_i = 1'b0; wr_tbl_i = '0; wr_addr_i = '0; wr_data_i = '0;
    req_valid_i = 1'b0; req_tbl_i = '0; req_addr_i = '0; zigzag_i = 1'b0; data_ready_i = 1'b1;

    // Reset state
    repeat (3) cycle();
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_data_valid", {31'd0, data_valid_o}, 32'd0);
    chk("rst_init_done", {31'd0, init_done_o}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);

    // INIT: random writes and requests must be ignored, ready stays low
    rst_ni = 1'b1;
    for (int i = 0; i < 128; i++) begin
      chk("init_done_early", {31'd0, init_done_o}, 32'd0);
      wr_en_i = 1'($urandom); wr_tbl_i = 2'($urandom); wr_addr_i = 6'($urandom);
      wr_data_i = 8'($urandom);
      req_valid_i = 1'($urandom); req_tbl_i = 2'($urandom); req_addr_i = 6'($urandom);
      cycle();
    end
    chk("init_done_128", {31'd0, init_done_o}, 32'd1);
    wr_en_i = 1'b0; req_valid_i = 1'b0;
    cycle();

    // Back-to-back tbl0/tbl1 raster 0
    req(2'd0, 6'd0, 1'b0);
    req(2'd1, 6'd0, 1'b0);
    req_valid_i = 1'b0;
    chk("b2b_first", data_o, 32'h4180_0000);
    cycle();
    chk("b2b_second", data_o, 32'h4188_0000);
    cycle(); cycle();

    // Zigzag reads
    read_chk("zz2", 2'd0, 6'd2, 1'b1, 32'h4140_0000);
    read_chk("zz63", 2'd0, 6'd63, 1'b1, 32'h42C6_0000);

    // Runtime writes
    wr(2'd0, 6'd5, 8'd255);
    read_chk("wr255", 2'd0, 6'd5, 1'b0, 32'h437F_0000);
    wr(2'd0, 6'd5, 8'd0);
    read_chk("wr0", 2'd0, 6'd5, 1'b0, 32'h3F80_0000);
    wr(2'd3, 6'd5, 8'd77);
    read_chk("wr_tbl3_t0", 2'd0, 6'd5, 1'b0, 32'h3F80_0000);
    read_chk("wr_tbl3_t1", 2'd1, 6'd5, 1'b0, 32'h42C6_0000);
    read_chk("rd_tbl2", 2'd2, 6'd5, 1'b0, 32'h0000_0000);

    // Same-cycle read and write of one entry
    wr_en_i = 1'b1; wr_tbl_i = 2'd0; wr_addr_i = 6'd5; wr_data_i = 8'd200;
    req(2'd0, 6'd5, 1'b0);
    wr_en_i = 1'b0;
    req(2'd0, 6'd5, 1'b0);
    req_valid_i = 1'b0;
    chk("rw_old", data_o, 32'h3F80_0000);
    cycle();
    chk("rw_new", data_o, 32'h4348_0000);
    cycle(); cycle();

    // Output stall with three requests outstanding
    data_ready_i = 1'b0;
    req(2'd0, 6'd1, 1'b0);
    req(2'd0, 6'd2, 1'b0);
    req_tbl_i = 2'd0; req_addr_i = 6'd3; zigzag_i = 1'b0; req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", {31'd0, data_valid_o}, 32'd1);
      chk("stall_dat", data_o, 32'h4130_0000);
      chk("stall_rdy", {31'd0, req_ready_o}, 32'd0);
      cycle();
    end
    data_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (acc) break;
    end
    req_valid_i = 1'b0;
    repeat (4) cycle();
    chk("stall_drained", 32'(q.size()), 32'd0);

    // Randomised traffic with backpressure and writes
    for (int i = 0; i < 300; i++) begin
      if (!req_valid_i || acc) begin
        req_valid_i = 1'($urandom); req_tbl_i = 2'($urandom);
        req_addr_i = 6'($urandom); zigzag_i = 1'($urandom);
      end
      data_ready_i = ($urandom_range(0, 3) != 0);
      wr_en_i = ($urandom_range(0, 3) == 0); wr_tbl_i = 2'($urandom);
      wr_addr_i = 6'($urandom); wr_data_i = 8'($urandom_range(0, 255));
      cycle();
    end
    req_valid_i = 1'b0; wr_en_i = 1'b0; data_ready_i = 1'b1;
    repeat (5) cycle();
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset mid-stream after a runtime write
    wr(2'd0, 6'd7, 8'd3);
    req(2'd0, 6'd7, 1'b0);
    req(2'd0, 6'd1, 1'b0);
    chk("pre_rst_dat", data_o, 32'h4040_0000);
    rst_ni = 1'b0; req_valid_i = 1'b0;
    cycle();
    chk("midrst_vld", {31'd0, data_valid_o}, 32'd0);
    chk("midrst_dat", data_o, 32'd0);
    chk("midrst_done", {31'd0, init_done_o}, 32'd0);
    chk("midrst_rdy", {31'd0, req_ready_o}, 32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 128; i++) cycle();
    chk("reinit_done", {31'd0, init_done_o}, 32'd1);
    read_chk("reinit_default", 2'd0, 6'd7, 1'b0, 32'h4274_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kuantalama_tablo.md
KUANTALAMA_TABLO -- requirements
Module: kuantalama_tablo

Interface
REQ-001 SHALL have parameter N_TABLE, default 2, number of 64-entry quantisation tables (legal 1..4).
REQ-002 SHALL have parameter DATA_W, default 32, output width: IEEE-754 single precision.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-005 SHALL have port wr_en_i, input, 1, table write strobe.
REQ-006 SHALL have port wr_tbl_i, input, 2, table index for the write.
REQ-007 SHALL have port wr_addr_i, input, 6, raster address for the write.
REQ-008 SHALL have port wr_data_i, input, 8, unsigned integer Q value to write.
REQ-009 SHALL have port req_valid_i, input, 1, read request valid.
REQ-010 SHALL have port req_ready_o, output, 1, read request accepted when high with req_valid_i.
REQ-011 SHALL have port req_tbl_i, input, 2, table index for the read.
REQ-012 SHALL have port req_addr_i, input, 6, read index.
REQ-013 SHALL have port zigzag_i, input, 1; 1 means req_addr_i is a zigzag index, 0 means raster.
REQ-014 SHALL have port data_valid_o, output, 1, data_o valid.
REQ-015 SHALL have port data_ready_i, input, 1, consumer accepts data_o.
REQ-016 SHALL have port data_o, output, DATA_W, Q value as IEEE-754 float.
REQ-017 SHALL have port init_done_o, output, 1, default tables loaded.

Function
REQ-018 SHALL store N_TABLE x 64 entries of 8-bit Q values.
REQ-019 SHALL run a two-state FSM: INIT, then RUN.
- INIT writes one entry per cycle, 64*N_TABLE cycles total.
- Table 0 gets JPEG Annex K luminance; tables 1..N_TABLE-1 get Annex K chrominance.
REQ-020 SHALL raise init_done_o in the cycle after the last INIT write, then enter RUN and stay there until reset.
REQ-021 SHALL hold req_ready_o low in INIT; in RUN, req_ready_o = !data_valid_o || data_ready_i.
REQ-022 SHALL accept a request when req_valid_i && req_ready_o.
REQ-023 SHALL use a 2-stage pipeline: stage 1 registered table read, stage 2 float conversion.
- Both stages advance only when req_ready_o is high.
REQ-024 SHALL assert data_valid_o with the result exactly 2 cycles after acceptance when unstalled, sustaining 1 result/cycle.
REQ-025 SHALL, while data_valid_o && !data_ready_i, hold data_o and data_valid_o stable and keep the pipeline frozen.
REQ-026 SHALL map zigzag index to raster address via an internal fixed 64-entry map (JPEG order: 0->0, 1->1, 2->8, 3->16, 63->63).
REQ-027 SHALL convert Q (1..255) to float as sign 0, exponent 127+msb(Q), mantissa = Q bits below msb left-aligned in 23 bits (16 -> 0x41800000, 1 -> 0x3F800000).
REQ-028 SHALL ignore writes in INIT and writes with wr_tbl_i >= N_TABLE.
REQ-029 SHALL store wr_data_i = 0 as 1.
REQ-030 SHALL return the old value when a read (stage 1) and a write hit the same entry in the same cycle; the new value is visible from the next cycle.
REQ-031 SHALL return data_o = 0x00000000 (still valid-handshaked) for reads with req_tbl_i >= N_TABLE.

Reset
REQ-032 SHALL, while rst_ni low at a clock edge, drive data_o=0, data_valid_o=0, init_done_o=0, req_ready_o=0, and clear pipeline valids.
REQ-033 SHALL restart INIT from entry 0 after reset release.
- Applies even mid-operation: in-flight results are discarded and all runtime writes are overwritten by defaults.

Verification
REQ-034 SHALL show: reset release, N_TABLE=2 -> init_done_o high after 128 INIT cycles; req_ready_o low throughout INIT.
REQ-035 SHALL show: read tbl0 raster 0, then tbl1 raster 0 back-to-back -> 0x41800000 (16), then 0x41880000 (17), on consecutive cycles, 2-cycle latency.
REQ-036 SHALL show: tbl0 zigzag 2 -> raster 8 -> Q 12 -> 0x41400000; tbl0 zigzag 63 -> Q 99 -> 0x42C60000.
REQ-037 SHALL show: write tbl0 addr 5 = 255 -> read 0x437F0000; write 0 -> read 0x3F800000; write tbl 3 (N_TABLE=2) -> no change; same-cycle read/write -> old value.
REQ-038 SHALL show: data_ready_i low 5 cycles with 3 requests pending -> data_o stable, req_ready_o low; on release all 3 results delivered in order, none lost or duplicated.
REQ-039 SHALL show: rst_ni pulsed low mid-stream after a runtime write -> data_valid_o 0 next cycle, INIT reruns, address rereads the default value.
